// File: rtl/al_const_pkg.sv
// ============================================================================
// Module : al_const_pkg
// Brief  : Shared sizes, state encoding and default constants for the
//          auto-load constant capture block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package al_const_pkg;

  localparam int NWORDS = 34;
  localparam int AW     = 6;
  localparam int DW     = 16;

  // Flash word address of constant word 0; the block spans 0x7FC000..0x7FC021
  // in the last flash parameter block.
  localparam logic [23:0] BASE_WADDR = 24'h7FC000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Word 33 is the 16-bit additive checksum of words 0..32.
  localparam logic [DW-1:0] DEFAULT_CONST [0:NWORDS-1] = '{
    16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006,
    16'h1007, 16'h1008, 16'h1009, 16'h100A, 16'h100B, 16'h100C, 16'h100D,
    16'h100E, 16'h100F, 16'h1010, 16'h1011, 16'h1012, 16'h1013, 16'h1014,
    16'h1015, 16'h1016, 16'h1017, 16'h1018, 16'h1019, 16'h101A, 16'h101B,
    16'h101C, 16'h101D, 16'h101E, 16'h101F, 16'h1020, 16'h1210
  };

endpackage

`default_nettype wire

// File: rtl/al_const_bank.sv
// ============================================================================
// Module : al_const_bank
// Brief  : NWORDS x DW constant register file, one write port and one
//          registered read port with default substitution.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module al_const_bank
  import al_const_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_use_bank,
  output logic [DW-1:0] o_rdata,
  output logic [DW-1:0] o_last_word
);

  logic [DW-1:0] r_mem [0:NWORDS-1];
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] w_rd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NWORDS; i++) r_mem[i] <= '0;
    end else if (i_we && (int'(i_waddr) < NWORDS)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range addresses read as zero in both bank and default mode.
  always_comb begin
    w_rd = '0;
    if (int'(i_raddr) < NWORDS) begin
      w_rd = i_use_bank ? r_mem[i_raddr] : DEFAULT_CONST[i_raddr];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rdata <= '0;
    else        r_rdata <= w_rd;
  end

  assign o_rdata     = r_rdata;
  assign o_last_word = r_mem[NWORDS-1];

endmodule

`default_nettype wire

// File: rtl/al_const_capture.sv
// ============================================================================
// Module : al_const_capture
// Brief  : Captures and checksums the auto-load constant block, hands AL_DONE
//          back to the sequencer and serves constants through a read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module al_const_capture
  import al_const_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          AL_START,
  input  logic          AUTO_LOAD_ENA,
  input  logic [AW-1:0] AL_CNT,
  input  logic          RD_VALID,
  input  logic [DW-1:0] RD_DATA_IN,
  input  logic          CLR_AL_DONE,
  output logic          AL_DONE,
  output logic          LOAD_BUSY,
  output logic          CONST_VALID,
  output logic          CSUM_ERR,
  output logic          SEQ_ERR,
  input  logic [AW-1:0] CFG_ADDR,
  output logic [DW-1:0] CFG_DATA
);

  state_t        r_state;
  logic [DW-1:0] r_sum;
  logic [AW-1:0] r_expect;
  logic          r_al_done;
  logic          r_busy;
  logic          r_const_valid;
  logic          r_csum_err;
  logic          r_seq_err;

  logic          w_strobe;
  logic          w_in_range;
  logic          w_capture;
  logic          w_last;
  logic [DW-1:0] w_last_word;

  // AL_START takes priority, so a strobe in its cycle is never a capture.
  assign w_strobe   = RD_VALID & AUTO_LOAD_ENA & (r_state == ST_LOADING) & ~AL_START;
  assign w_in_range = (int'(AL_CNT) < NWORDS);
  assign w_capture  = w_strobe & w_in_range;
  assign w_last     = (int'(AL_CNT) == NWORDS - 1);

  al_const_bank u_bank (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .i_we        (w_capture),
    .i_waddr     (AL_CNT),
    .i_wdata     (RD_DATA_IN),
    .i_raddr     (CFG_ADDR),
    .i_use_bank  (r_const_valid),
    .o_rdata     (CFG_DATA),
    .o_last_word (w_last_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_sum         <= '0;
      r_expect      <= '0;
      r_al_done     <= 1'b0;
      r_busy        <= 1'b0;
      r_const_valid <= 1'b0;
      r_csum_err    <= 1'b0;
      r_seq_err     <= 1'b0;
    end else if (AL_START) begin
      r_state       <= ST_LOADING;
      r_busy        <= 1'b1;
      r_sum         <= '0;
      r_expect      <= '0;
      r_al_done     <= 1'b0;
      r_const_valid <= 1'b0;
      r_csum_err    <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      if (CLR_AL_DONE) r_al_done <= 1'b0;
      case (r_state)
        ST_LOADING: begin
          if (w_strobe) begin
            if (w_in_range) begin
              // Set beats the same-cycle CLR_AL_DONE above.
              r_al_done <= 1'b1;
              r_expect  <= AL_CNT + AW'(1);
              if ((AL_CNT != r_expect) || r_al_done) r_seq_err <= 1'b1;
              if (w_last) r_state <= ST_CHECK;
              else        r_sum   <= r_sum + RD_DATA_IN;
            end else begin
              r_seq_err <= 1'b1;
            end
          end else if (!AUTO_LOAD_ENA) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_csum_err    <= (w_last_word != r_sum);
          r_const_valid <= (w_last_word == r_sum) & ~r_seq_err;
          r_state       <= ST_DONE;
          r_busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign AL_DONE     = r_al_done;
  assign LOAD_BUSY   = r_busy;
  assign CONST_VALID = r_const_valid;
  assign CSUM_ERR    = r_csum_err;
  assign SEQ_ERR     = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_al_const_capture.sv
// ============================================================================
// Module : tb_al_const_capture
// Brief  : Self-checking bench for al_const_capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_al_const_capture;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        AL_START = 1'b0;
  logic        AUTO_LOAD_ENA = 1'b0;
  logic [5:0]  AL_CNT = '0;
  logic        RD_VALID = 1'b0;
  logic [15:0] RD_DATA_IN = '0;
  logic        CLR_AL_DONE = 1'b0;
  logic [5:0]  CFG_ADDR = '0;
  logic        AL_DONE;
  logic        LOAD_BUSY;
  logic        CONST_VALID;
  logic        CSUM_ERR;
  logic        SEQ_ERR;
  logic [15:0] CFG_DATA;

  al_const_capture dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .AL_START      (AL_START),
    .AUTO_LOAD_ENA (AUTO_LOAD_ENA),
    .AL_CNT        (AL_CNT),
    .RD_VALID      (RD_VALID),
    .RD_DATA_IN    (RD_DATA_IN),
    .CLR_AL_DONE   (CLR_AL_DONE),
    .AL_DONE       (AL_DONE),
    .LOAD_BUSY     (LOAD_BUSY),
    .CONST_VALID   (CONST_VALID),
    .CSUM_ERR      (CSUM_ERR),
    .SEQ_ERR       (SEQ_ERR),
    .CFG_ADDR      (CFG_ADDR),
    .CFG_DATA      (CFG_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] exp_bank;
    logic [15:0] exp_def;
  } rd_vec_t;

  rd_vec_t     tbl [6];
  logic [15:0] sb_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_read(input string name, input logic [5:0] a, input logic [15:0] e);
    logic [15:0] exp;
    CFG_ADDR = a;
    sb_q.push_back(e);
    tick();
    exp = sb_q.pop_front();
    check(name, CFG_DATA, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_al_done"}, AL_DONE, 0);
    check({tag, "_busy"}, LOAD_BUSY, 0);
    check({tag, "_valid"}, CONST_VALID, 0);
    check({tag, "_csum"}, CSUM_ERR, 0);
    check({tag, "_seq"}, SEQ_ERR, 0);
    check({tag, "_cfg_data"}, CFG_DATA, 0);
  endtask

  task automatic start_load();
    AUTO_LOAD_ENA = 1'b1;
    AL_START = 1'b1;
    tick();
    AL_START = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [15:0] data, input bit clr);
    AL_CNT = 6'(idx);
    RD_DATA_IN = data;
    RD_VALID = 1'b1;
    tick();
    RD_VALID = 1'b0;
    if (clr) begin
      CLR_AL_DONE = 1'b1;
      tick();
      CLR_AL_DONE = 1'b0;
    end
  endtask

  // Words 0..32 carry idx+1 (checksum 0x0231); word 33 carries w33.
  task automatic load_words(input int first, input int last, input logic [15:0] w33,
                            input int skip_clr);
    for (int i = first; i <= last; i++) begin
      send_word(i, (i == 33) ? w33 : 16'(i + 1), i != skip_clr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{6'd0,  16'h0001, 16'h1000};
    tbl[1] = '{6'd5,  16'h0006, 16'h1005};
    tbl[2] = '{6'd32, 16'h0021, 16'h1020};
    tbl[3] = '{6'd33, 16'h0231, 16'h1210};
    tbl[4] = '{6'd34, 16'h0000, 16'h0000};
    tbl[5] = '{6'd63, 16'h0000, 16'h0000};

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();

    // Clean load
    start_load();
    check("start_busy", LOAD_BUSY, 1);
    send_word(0, 16'h0001, 0);
    check("first_al_done", AL_DONE, 1);
    CLR_AL_DONE = 1'b1; tick(); CLR_AL_DONE = 1'b0;
    check("clr_al_done", AL_DONE, 0);
    load_words(1, 33, 16'h0231, 99);
    check("clean_valid", CONST_VALID, 1);
    check("clean_csum", CSUM_ERR, 0);
    check("clean_seq", SEQ_ERR, 0);
    check("clean_busy", LOAD_BUSY, 0);
    for (int i = 0; i < 6; i++) cfg_read("clean_rd", tbl[i].addr, tbl[i].exp_bank);

    // RD_VALID ignored in DONE
    send_word(5, 16'hDEAD, 0);
    check("done_ignore_al_done", AL_DONE, 0);
    cfg_read("done_ignore_rd", 6'd5, 16'h0006);

    // Bad checksum
    start_load();
    load_words(0, 33, 16'h0000, 99);
    check("bad_csum", CSUM_ERR, 1);
    check("bad_valid", CONST_VALID, 0);
    tick();
    for (int i = 0; i < 6; i++) cfg_read("bad_rd", tbl[i].addr, tbl[i].exp_def);

    // Overrun: no CLR_AL_DONE between words 3 and 4
    start_load();
    load_words(0, 33, 16'h0231, 3);
    check("ovr_seq", SEQ_ERR, 1);
    check("ovr_valid", CONST_VALID, 0);
    check("ovr_csum", CSUM_ERR, 0);

    // Abort after word 10
    start_load();
    load_words(0, 10, 16'h0231, 99);
    AUTO_LOAD_ENA = 1'b0;
    tick(); tick();
    check("abort_busy", LOAD_BUSY, 0);
    check("abort_valid", CONST_VALID, 0);
    check("abort_csum", CSUM_ERR, 0);
    check("abort_seq", SEQ_ERR, 0);
    start_load();
    load_words(0, 33, 16'h0231, 99);
    check("post_abort_valid", CONST_VALID, 1);

    // Set/clear conflict, out-of-range index, restart mid-load
    start_load();
    AL_CNT = 6'd0; RD_DATA_IN = 16'h0001; RD_VALID = 1'b1; CLR_AL_DONE = 1'b1;
    tick();
    RD_VALID = 1'b0;
    check("conflict_set_wins", AL_DONE, 1);
    tick();
    CLR_AL_DONE = 1'b0;
    check("conflict_then_clr", AL_DONE, 0);
    load_words(1, 20, 16'h0231, 99);
    send_word(40, 16'hBEEF, 0);
    check("oor_seq", SEQ_ERR, 1);
    check("oor_al_done", AL_DONE, 0);
    start_load();
    check("restart_seq", SEQ_ERR, 0);
    check("restart_valid", CONST_VALID, 0);
    check("restart_busy", LOAD_BUSY, 1);
    load_words(0, 33, 16'h0231, 99);
    check("restart_valid_end", CONST_VALID, 1);
    check("restart_csum_end", CSUM_ERR, 0);
    cfg_read("restart_rd", 6'd5, 16'h0006);

    // Reset mid-load at word 15
    start_load();
    load_words(0, 14, 16'h0231, 99);
    AL_CNT = 6'd15; RD_DATA_IN = 16'h0010; RD_VALID = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midrst");
    RD_VALID = 1'b0;
    AUTO_LOAD_ENA = 1'b0;
    tick(); tick();
    check_all_zero("midrst_hold");
    RST_N = 1'b1;
    tick();
    check("post_rst_valid", CONST_VALID, 0);
    cfg_read("post_rst_rd", 6'd5, 16'h1005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
